// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter sharing one single-port byte store among NUM_REQ requesters.
// Tracks store occupancy and returns read data to the granted requester after RD_LAT cycles.
module rr_port_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 16,
    parameter  int RD_LAT  = 1,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_op,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        res_wr,
    output logic                        res_rd,
    output logic [DATA_W-1:0]           res_in,
    input  logic [DATA_W-1:0]           res_out,
    output logic [OCC_W-1:0]            occupancy,
    output logic                        full,
    output logic                        empty
);

    localparam int                SUM_W    = ID_W + 1;
    localparam int                CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [SUM_W-1:0]  NUM_SUM  = SUM_W'(NUM_REQ);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0]  CNT_CAPT = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RD_WAIT} state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     sel;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_REQ-1:0]  elig;
    logic                found;
    logic [ID_W-1:0]     pick;
    logic [SUM_W-1:0]    idx;

    // A write needs room, a read needs data; blocked requesters are skipped.
    assign elig = req & ((req_op & {NUM_REQ{~full}}) | (~req_op & {NUM_REQ{~empty}}));

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + SUM_W'(k);
            if (idx >= NUM_SUM)
                idx = idx - NUM_SUM;
            if (!found && elig[idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            sel       <= '0;
            cnt       <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            gnt       <= '0;
            res_wr    <= 1'b0;
            res_rd    <= 1'b0;
            res_in    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            gnt       <= '0;
            res_wr    <= 1'b0;
            res_rd    <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        sel    <= pick;
                        gnt    <= NUM_REQ'(1) << pick;
                        res_in <= req_data[pick*DATA_W +: DATA_W];
                        res_wr <= req_op[pick];
                        res_rd <= ~req_op[pick];
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    rr_ptr <= (sel == LAST_ID) ? '0 : sel + 1'b1;
                    // res_wr is high during GRANT exactly when the selection is a write.
                    if (res_wr) begin
                        occupancy <= occupancy + 1'b1;
                        full      <= (occupancy + 1'b1 == OCC_FULL);
                        empty     <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        occupancy <= occupancy - 1'b1;
                        full      <= 1'b0;
                        empty     <= (occupancy == OCC_W'(1));
                        cnt       <= CNT_W'(1);
                        if (RD_LAT == 1) begin
                            rsp_data  <= res_out;
                            rsp_id    <= sel;
                            rsp_valid <= 1'b1;
                        end
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // rsp_valid is visible in the final wait cycle, RD_LAT cycles after res_rd.
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_CAPT) begin
                            rsp_data  <= res_out;
                            rsp_id    <= sel;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Self-checking bench for rr_port_arbiter: grant and response scoreboards plus a FIFO store model
// whose read data appears RD_LAT-1 cycles after the res_rd cycle.
module tb_rr_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int RD_LAT  = 3;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int OCC_W   = $clog2(DEPTH + 1);

    typedef struct {
        int                idx;
        bit                wr;
        logic [DATA_W-1:0] data;
        int                gap;
    } gnt_exp_t;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_exp_t;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         req_op;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [DATA_W-1:0]          rsp_data;
    logic                       res_wr;
    logic                       res_rd;
    logic [DATA_W-1:0]          res_in;
    logic [DATA_W-1:0]          res_out;
    logic [OCC_W-1:0]           occupancy;
    logic                       full;
    logic                       empty;

    rr_port_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_data(req_data),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .res_wr(res_wr), .res_rd(res_rd), .res_in(res_in), .res_out(res_out),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte store: FIFO contents plus a read pipeline that sets the data latency.
    logic [DATA_W-1:0] store_q[$];
    logic [DATA_W-1:0] pipe [RD_LAT-1];
    assign res_out = pipe[RD_LAT-2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q.delete();
            for (int i = 0; i < RD_LAT - 1; i++) pipe[i] <= '0;
        end else begin
            for (int i = 1; i < RD_LAT - 1; i++) pipe[i] <= pipe[i-1];
            pipe[0] <= '0;
            if (res_wr) store_q.push_back(res_in);
            if (res_rd && store_q.size() > 0) begin
                pipe[0] <= store_q[0];
                void'(store_q.pop_front());
            end
        end
    end

    int       n_checks = 0;
    int       n_errors = 0;
    int       cyc = 0;
    int       last_gnt_cyc = 0;
    bit       auto_drop = 1'b0;
    gnt_exp_t gnt_q[$];
    rsp_exp_t rsp_q[$];
    int       rd_cyc[$];
    int       rsp_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sample();
        gnt_exp_t e;
        rsp_exp_t r;
        check("gnt_onehot0", 32'($onehot0(gnt)), 1);
        check("wr_rd_excl", 32'(res_wr & res_rd), 0);
        check("strobe_with_gnt", 32'(res_wr | res_rd), 32'(|gnt));
        check("occupancy", 32'(occupancy), store_q.size());
        check("full", 32'(full), 32'(store_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(store_q.size() == 0));
        if (res_rd) rd_cyc.push_back(cyc);
        if (gnt != '0) begin
            if (gnt_q.size() == 0) begin
                check("unexpected_gnt", 32'(gnt), 0);
            end else begin
                e = gnt_q.pop_front();
                check("gnt_idx", 32'(gnt), 32'(1) << e.idx);
                check("gnt_res_wr", 32'(res_wr), 32'(e.wr));
                check("gnt_res_rd", 32'(res_rd), 32'(!e.wr));
                if (e.wr) check("res_in", 32'(res_in), 32'(e.data));
                if (e.gap != 0) check("gnt_gap", cyc - last_gnt_cyc, e.gap);
                if (!e.wr) begin
                    r.id   = e.idx;
                    r.data = (store_q.size() > 0) ? store_q[0] : 'x;
                    r.due  = cyc + RD_LAT;
                    rsp_q.push_back(r);
                end
            end
            last_gnt_cyc = cyc;
        end
        if (rsp_valid) begin
            rsp_cyc.push_back(cyc);
            if (rsp_q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_id", 32'(rsp_id), r.id);
                check("rsp_data", 32'(rsp_data), 32'(r.data));
                check("rsp_time", cyc, r.due);
            end
        end
    endtask

    // One clock: sample at the falling edge, drive just after the rising edge.
    task automatic tick();
        logic [NUM_REQ-1:0] g;
        @(negedge clk);
        sample();
        g = gnt;
        @(posedge clk);
        #1;
        cyc++;
        if (auto_drop) req = req & ~g;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((gnt_q.size() != 0 || rsp_q.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_timeout", gnt_q.size() + rsp_q.size(), 0);
    endtask

    task automatic expect_gnt(input int idx, input bit wr, input logic [DATA_W-1:0] data, input int gap);
        gnt_exp_t e;
        e.idx = idx; e.wr = wr; e.data = data; e.gap = gap;
        gnt_q.push_back(e);
    endtask

    task automatic drive(input int i, input bit wr, input logic [DATA_W-1:0] data);
        req_op[i] = wr;
        req_data[i*DATA_W +: DATA_W] = data;
        req[i] = 1'b1;
    endtask

    task automatic do_xfer(input int i, input bit wr, input logic [DATA_W-1:0] data);
        expect_gnt(i, wr, data, 0);
        drive(i, wr, data);
        wait_idle(40);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        req      = '1;
        req_op   = '1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(8'h10 + i);
        #1;
        repeat (3) tick();

        // Reset state with every requester asserting a write
        check("rst_gnt", 32'(gnt), 0);
        check("rst_res_wr", 32'(res_wr), 0);
        check("rst_res_rd", 32'(res_rd), 0);
        check("rst_res_in", 32'(res_in), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);

        // Held writes: grants 0,1,2,3,0 one every second cycle
        expect_gnt(0, 1, 8'h10, 0);
        expect_gnt(1, 1, 8'h11, 2);
        expect_gnt(2, 1, 8'h12, 2);
        expect_gnt(3, 1, 8'h13, 2);
        expect_gnt(0, 1, 8'h10, 2);
        rst_n = 1'b1;
        repeat (9) tick();
        req = '0;
        wait_idle(10);
        check("t1_occupancy", 32'(occupancy), 5);

        // Fill to DEPTH, then a write is blocked until a read frees an entry
        auto_drop = 1'b1;
        for (int k = 0; k < DEPTH - 5; k++) do_xfer(0, 1, DATA_W'(8'h20 + k));
        check("t2_full", 32'(full), 1);
        check("t2_occupancy_full", 32'(occupancy), DEPTH);
        drive(0, 1, 8'h55);
        repeat (6) begin
            tick();
            check("t2_req0_blocked", 32'(gnt[0]), 0);
        end
        expect_gnt(1, 0, '0, 0);
        expect_gnt(0, 1, 8'h55, 0);
        drive(1, 0, '0);
        wait_idle(40);
        check("t2_occupancy", 32'(occupancy), DEPTH);

        // Drain the store; data must come back in write order
        for (int k = 0; k < DEPTH; k++) do_xfer(k % NUM_REQ, 0, '0);
        check("t3_empty", 32'(empty), 1);
        check("t3_occupancy", 32'(occupancy), 0);

        // Read at empty is skipped until another requester writes
        drive(2, 0, '0);
        repeat (8) begin
            tick();
            check("t3_no_res_rd", 32'(res_rd), 0);
        end
        expect_gnt(3, 1, 8'hA5, 0);
        expect_gnt(2, 0, '0, 0);
        drive(3, 1, 8'hA5);
        wait_idle(40);

        // Back-to-back reads from requesters 1 and 2
        do_xfer(0, 1, 8'h31);
        do_xfer(0, 1, 8'h32);
        rd_cyc.delete();
        rsp_cyc.delete();
        expect_gnt(1, 0, '0, 0);
        expect_gnt(2, 0, '0, 0);
        drive(1, 0, '0);
        drive(2, 0, '0);
        wait_idle(60);
        check("t4_rd_count", rd_cyc.size(), 2);
        check("t4_rsp_count", rsp_cyc.size(), 2);
        if (rd_cyc.size() == 2 && rsp_cyc.size() == 2)
            check("t4_rd_after_rsp", 32'(rd_cyc[1] >= rsp_cyc[0] + 1), 1);

        // Pointer sits at 3: requester 0 wins over 1 by wrap-around
        expect_gnt(0, 1, 8'h61, 0);
        expect_gnt(1, 1, 8'h62, 0);
        drive(0, 1, 8'h61);
        drive(1, 1, 8'h62);
        wait_idle(40);
        check("t6_occupancy", 32'(occupancy), 2);

        // Reset while a read is outstanding
        expect_gnt(2, 0, '0, 0);
        drive(2, 0, '0);
        n = rd_cyc.size();
        for (int k = 0; k < 20 && rd_cyc.size() == n; k++) tick();
        check("t5_read_issued", 32'(rd_cyc.size() > n), 1);
        tick();
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("t5_rst_gnt", 32'(gnt), 0);
        check("t5_rst_res_rd", 32'(res_rd), 0);
        check("t5_rst_rsp_valid", 32'(rsp_valid), 0);
        check("t5_rst_occupancy", 32'(occupancy), 0);
        check("t5_rst_empty", 32'(empty), 1);
        rsp_q.delete();
        gnt_q.delete();
        #1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("t5_occupancy", 32'(occupancy), 0);
        check("final_pending", gnt_q.size() + rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
